// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller:
// state encoding, opcodes and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_WBL   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_EXI   = 4'd8,
    S_WBI   = 4'd9,
    S_BEQ   = 4'd10,
    S_JMP   = 4'd11
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation codes
  localparam logic [2:0] ALUOP_FUNCT = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                                                op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore-style main controller for a multi-cycle MIPS datapath.
// Strobes are decoded from the current state (some qualified by the
// memory ready handshake) and are forced low while reset is held.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic             RegDst_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  // Ungated strobes, masked by reset before reaching the ports
  logic w_pcwrite;
  logic w_pcwritecond;
  logic w_memread;
  logic w_memwrite;
  logic w_irwrite;
  logic w_regwrite;
  logic w_done;
  logic w_illegal;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Next-state decode; unreachable encodings fall back to fetch
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:    w_next = mem_ready_i ? S_ID : S_IF;
      S_ID: begin
        case (instr_op_i)
          OP_LW, OP_SW:     w_next = S_MADDR;
          OP_RTYPE:         w_next = S_EXR;
          OP_ADDI, OP_SLTI: w_next = S_EXI;
          OP_BEQ:           w_next = S_BEQ;
          OP_J:             w_next = S_JMP;
          default:          w_next = S_IF;
        endcase
      end
      S_MADDR: w_next = (instr_op_i == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   w_next = mem_ready_i ? S_WBL : S_MRD;
      S_WBL:   w_next = S_IF;
      S_MWR:   w_next = mem_ready_i ? S_IF : S_MWR;
      S_EXR:   w_next = S_WBR;
      S_WBR:   w_next = S_IF;
      S_EXI:   w_next = S_WBI;
      S_WBI:   w_next = S_IF;
      S_BEQ:   w_next = S_IF;
      S_JMP:   w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  // Per-state datapath controls; everything defaults to 0
  always_comb begin
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_regwrite    = 1'b0;
    w_done        = 1'b0;
    w_illegal     = 1'b0;
    IorD_o        = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_REG;
    ALUOp_o       = ALUOP_FUNCT;
    PCSource_o    = PCSRC_ALU;
    case (r_state)
      S_IF: begin
        w_memread  = 1'b1;
        w_irwrite  = mem_ready_i;
        w_pcwrite  = mem_ready_i;
        ALUSrcB_o  = SRCB_FOUR;
        ALUOp_o    = ALUOP_ADD;
      end
      S_ID: begin
        // Branch target is computed speculatively into ALUOut here
        ALUSrcB_o  = SRCB_IMMSH;
        ALUOp_o    = ALUOP_ADD;
        w_illegal  = ~op_is_legal(instr_op_i);
      end
      S_MADDR: begin
        ALUSrcA_o  = 1'b1;
        ALUSrcB_o  = SRCB_IMM;
        ALUOp_o    = ALUOP_ADD;
      end
      S_MRD: begin
        w_memread  = 1'b1;
        IorD_o     = 1'b1;
      end
      S_WBL: begin
        w_regwrite = 1'b1;
        MemtoReg_o = 1'b1;
        w_done     = 1'b1;
      end
      S_MWR: begin
        w_memwrite = 1'b1;
        IorD_o     = 1'b1;
        w_done     = mem_ready_i;
      end
      S_EXR: begin
        ALUSrcA_o  = 1'b1;
        ALUSrcB_o  = SRCB_REG;
        ALUOp_o    = ALUOP_FUNCT;
      end
      S_WBR: begin
        w_regwrite = 1'b1;
        RegDst_o   = 1'b1;
        w_done     = 1'b1;
      end
      S_EXI: begin
        ALUSrcA_o  = 1'b1;
        ALUSrcB_o  = SRCB_IMM;
        ALUOp_o    = (instr_op_i == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
      end
      S_WBI: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA_o     = 1'b1;
        ALUSrcB_o     = SRCB_REG;
        ALUOp_o       = ALUOP_SUB;
        w_pcwritecond = 1'b1;
        PCSource_o    = PCSRC_ALUOUT;
        w_done        = 1'b1;
      end
      S_JMP: begin
        w_pcwrite  = 1'b1;
        PCSource_o = PCSRC_JUMP;
        w_done     = 1'b1;
      end
      default: begin
        w_pcwrite = 1'b0;
      end
    endcase
  end

  // Strobes are held low for as long as reset is asserted
  always_comb begin
    PCWrite_o     = w_pcwrite     & ~rst_i;
    PCWriteCond_o = w_pcwritecond & ~rst_i;
    MemRead_o     = w_memread     & ~rst_i;
    MemWrite_o    = w_memwrite    & ~rst_i;
    IRWrite_o     = w_irwrite     & ~rst_i;
    RegWrite_o    = w_regwrite    & ~rst_i;
    instr_done_o  = w_done        & ~rst_i;
    illegal_o     = w_illegal     & ~rst_i;
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_retired <= '0;
    else if (w_done) r_retired <= r_retired + CNT_W'(1);
  end

  assign retired_o = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl. Each table row is one
// clock cycle: inputs applied on the falling edge, outputs sampled 1ns later.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op;
  logic          rdy;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic [2:0]    ALUOp;
  logic [1:0]    PCSource;
  logic          done, illegal;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(rdy),
    .PCWrite_o(PCWrite), .PCWriteCond_o(PCWriteCond), .IorD_o(IorD),
    .MemRead_o(MemRead), .MemWrite_o(MemWrite), .IRWrite_o(IRWrite),
    .MemtoReg_o(MemtoReg), .RegWrite_o(RegWrite), .RegDst_o(RegDst),
    .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .ALUOp_o(ALUOp),
    .PCSource_o(PCSource), .instr_done_o(done), .illegal_o(illegal),
    .retired_o(retired)
  );

  // Output vector order:
  // {PCW,PCWC,IorD,MR,MW,IRW,M2R,RW,RDst,SrcA,SrcB[2],ALUOp[3],PCSrc[2],done,ill}
  localparam logic [18:0] E_RST    = {10'b0000000000, 2'b01, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_IF_RDY = {10'b1001010000, 2'b01, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_IF_WT  = {10'b0001000000, 2'b01, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_ID     = {10'b0000000000, 2'b11, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_ID_ILL = {10'b0000000000, 2'b11, 3'b100, 2'b00, 2'b01};
  localparam logic [18:0] E_MADDR  = {10'b0000000001, 2'b10, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_MRD    = {10'b0011000000, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_WBL    = {10'b0000001100, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] E_MWR_WT = {10'b0010100000, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_MWR    = {10'b0010100000, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] E_EXR    = {10'b0000000001, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_WBR    = {10'b0000000110, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] E_EXI_A  = {10'b0000000001, 2'b10, 3'b100, 2'b00, 2'b00};
  localparam logic [18:0] E_EXI_S  = {10'b0000000001, 2'b10, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] E_WBI    = {10'b0000000100, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] E_BEQ    = {10'b0100000001, 2'b00, 3'b001, 2'b01, 2'b10};
  localparam logic [18:0] E_JMP    = {10'b1000000000, 2'b00, 3'b000, 2'b10, 2'b10};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;
  localparam logic [5:0] SI = 6'b001010, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t          tbl[$];
  int            checks = 0;
  int            failures = 0;
  int            row = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [18:0]   got;

  function automatic vec_t mk(input logic r, input logic [5:0] o,
                              input logic y, input logic [18:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = y; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; op = v.op; rdy = v.rdy;
    #1;
    got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, done, illegal};
    if (v.rst) exp_cnt = '0;
    checks++;
    if (got !== v.exp) begin
      failures++;
      $display("FAIL row%0d outputs got=%b exp=%b", row, got, v.exp);
    end
    checks++;
    if (retired !== exp_cnt) begin
      failures++;
      $display("FAIL row%0d retired got=%0d exp=%0d", row, retired, exp_cnt);
    end
    checks++;
    if ((MemRead && MemWrite) || (PCWrite && PCWriteCond)) begin
      failures++;
      $display("FAIL row%0d exclusive_strobes got MR=%b MW=%b PCW=%b PCWC=%b exp no overlap",
               row, MemRead, MemWrite, PCWrite, PCWriteCond);
    end
    if (!v.rst && v.exp[1]) exp_cnt = exp_cnt + 1'b1;
    row++;
  endtask

  initial begin
    rst = 1'b1; op = '0; rdy = 1'b0;

    // Reset, then R-type with zero-wait memory
    tbl.push_back(mk(1, R, 1, E_RST));
    tbl.push_back(mk(0, R, 1, E_IF_RDY));
    tbl.push_back(mk(0, R, 1, E_ID));
    tbl.push_back(mk(0, R, 1, E_EXR));
    tbl.push_back(mk(0, R, 1, E_WBR));
    // Second R-type interrupted by reset during EXR
    tbl.push_back(mk(0, R, 1, E_IF_RDY));
    tbl.push_back(mk(0, R, 1, E_ID));
    tbl.push_back(mk(1, R, 1, E_RST));
    // lw with two wait cycles in MRD
    tbl.push_back(mk(0, LW, 1, E_IF_RDY));
    tbl.push_back(mk(0, LW, 1, E_ID));
    tbl.push_back(mk(0, LW, 1, E_MADDR));
    tbl.push_back(mk(0, LW, 0, E_MRD));
    tbl.push_back(mk(0, LW, 0, E_MRD));
    tbl.push_back(mk(0, LW, 1, E_MRD));
    tbl.push_back(mk(0, LW, 1, E_WBL));
    // sw with a fetch wait and a write wait
    tbl.push_back(mk(0, SW, 0, E_IF_WT));
    tbl.push_back(mk(0, SW, 1, E_IF_RDY));
    tbl.push_back(mk(0, SW, 1, E_ID));
    tbl.push_back(mk(0, SW, 1, E_MADDR));
    tbl.push_back(mk(0, SW, 0, E_MWR_WT));
    tbl.push_back(mk(0, SW, 1, E_MWR));
    // beq, j
    tbl.push_back(mk(0, BQ, 1, E_IF_RDY));
    tbl.push_back(mk(0, BQ, 1, E_ID));
    tbl.push_back(mk(0, BQ, 1, E_BEQ));
    tbl.push_back(mk(0, JJ, 1, E_IF_RDY));
    tbl.push_back(mk(0, JJ, 1, E_ID));
    tbl.push_back(mk(0, JJ, 1, E_JMP));
    // addi, slti
    tbl.push_back(mk(0, AI, 1, E_IF_RDY));
    tbl.push_back(mk(0, AI, 1, E_ID));
    tbl.push_back(mk(0, AI, 1, E_EXI_A));
    tbl.push_back(mk(0, AI, 1, E_WBI));
    tbl.push_back(mk(0, SI, 1, E_IF_RDY));
    tbl.push_back(mk(0, SI, 1, E_ID));
    tbl.push_back(mk(0, SI, 1, E_EXI_S));
    tbl.push_back(mk(0, SI, 1, E_WBI));
    // Illegal opcode returns straight to fetch, then a j
    tbl.push_back(mk(0, BAD, 1, E_IF_RDY));
    tbl.push_back(mk(0, BAD, 1, E_ID_ILL));
    tbl.push_back(mk(0, JJ, 1, E_IF_RDY));
    tbl.push_back(mk(0, JJ, 1, E_ID));
    tbl.push_back(mk(0, JJ, 1, E_JMP));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Retire j instructions until the counter reaches all-ones
    for (int k = 0; k < 20 && exp_cnt != {CW{1'b1}}; k++) begin
      apply(mk(0, JJ, 1, E_IF_RDY));
      apply(mk(0, JJ, 1, E_ID));
      apply(mk(0, JJ, 1, E_JMP));
    end
    apply(mk(0, JJ, 1, E_IF_RDY));
    checks++;
    if (retired !== 4'hF) begin
      failures++;
      $display("FAIL wrap_allones retired got=%0d exp=15", retired);
    end
    apply(mk(0, JJ, 1, E_ID));
    apply(mk(0, JJ, 1, E_JMP));
    apply(mk(0, R, 1, E_IF_RDY));
    checks++;
    if (retired !== 4'h0) begin
      failures++;
      $display("FAIL wrap_zero retired got=%0d exp=0", retired);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style main controller for the multi-cycle MIPS datapath. It sequences a shared memory, ALU, register file and PC through the fetch, decode, execute, memory and write-back steps. It stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions. Supported opcodes are R-type, addi, slti, lw, sw, beq and j.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
instr_op_i  in  6  opcode from instruction register; stable from the cycle after IRWrite_o
mem_ready_i  in  1  memory completes the current access this cycle
PCWrite_o  out  1  unconditional PC write
PCWriteCond_o  out  1  PC write qualified by ALU zero (beq)
IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  instruction register load
MemtoReg_o  out  1  write-back data select: 1 = MDR, 0 = ALUOut
RegWrite_o  out  1  register file write
RegDst_o  out  1  destination register select: 1 = rd, 0 = rt
ALUSrcA_o  out  1  ALU A select: 0 = PC, 1 = reg A
ALUSrcB_o  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp_o  out  3  000 = R-type (funct), 100 = add, 010 = slt, 001 = sub
PCSource_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done_o  out  1  one-cycle pulse on the cycle an instruction retires
illegal_o  out  1  one-cycle pulse when an unknown opcode is decoded
retired_o  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst_i=1): state goes to IF and retired_o clears to 0. While rst_i is high, every strobe (PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, instr_done, illegal) is forced to 0.
- Reset mid-instruction abandons the instruction. It is not counted.
- Selects default to 0 in every state unless listed below.
- Strobes are decoded from the current state, qualified by mem_ready_i where noted.
- IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00.
  - IRWrite and PCWrite are high only when mem_ready_i=1.
  - Stay in IF while mem_ready_i=0; go to ID when it is 1.
- ID: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target into ALUOut). Next state by opcode:
  - lw (100011) or sw (101011): MADDR
  - R-type (000000): EXR
  - addi (001000) or slti (001010): EXI
  - beq (000100): BEQ
  - j (000010): JMP
  - any other opcode: illegal_o=1, next state IF, no register or memory side effects
- MADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. Next state MRD for lw, MWR for sw.
- MRD: MemRead=1, IorD=1. Stay while mem_ready_i=0; go to WBL when ready.
- WBL: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state IF.
- MWR: MemWrite=1, IorD=1. Stay while mem_ready_i=0. When ready: instr_done=1, next state IF.
- EXR: ALUSrcA=1, ALUSrcB=00, ALUOp=000. Next state WBR.
- WBR: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next state IF.
- EXI: ALUSrcA=1, ALUSrcB=10. ALUOp=100 for addi, 010 for slti. Next state WBI.
- WBI: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next state IF.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, instr_done=1. Next state IF.
- JMP: PCWrite=1, PCSource=10, instr_done=1. Next state IF.
- Latency with zero-wait memory (mem_ready_i tied 1), in cycles: R 4, addi/slti 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- retired_o increments by 1 on every instr_done pulse. It wraps from all-ones to 0.
- MemRead and MemWrite are never asserted together.
- PCWrite and PCWriteCond are never asserted together.
- The next state is always a legal encoding. Unreachable encodings go to IF.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum (IF, ID, MADDR, MRD, WBL, MWR, EXR, WBR, EXI, WBI, BEQ, JMP)
  - opcode constants
  - ALUOp constants (000, 100, 010, 001)
  - ALUSrcB constants (00, 01, 10, 11)
  - PCSource constants (00, 01, 10)
- Single module with no sub-modules. The retire counter is an inline register.

Test Plan:
- rst_i pulsed mid-EXR, mem_ready_i=1 -> all strobes 0 during reset; after release IF with MemRead=1, retired_o=0, interrupted instruction never counted.
- R-type 000000, mem_ready_i=1 -> states IF, ID, EXR, WBR; RegWrite=1 and RegDst=1 in cycle 4; instr_done pulse in cycle 4; retired_o=1.
- lw 100011 with mem_ready_i low for 2 cycles in MRD -> MRD held 3 cycles; WBL asserts RegWrite and MemtoReg; total 7 cycles.
- sw then beq then j, ready=1 -> MWR MemWrite=1 (4 cycles); BEQ PCWriteCond=1 with PCSource=01 (3 cycles); JMP PCWrite=1 with PCSource=10 (3 cycles); retired_o +3.
- addi 001000 then slti 001010 -> ALUOp 100 then 010 in EXI, ALUSrcB=10; WBI RegWrite=1 with RegDst=0.
- Opcode 111111 -> illegal_o pulse in ID, next state IF, no RegWrite or MemWrite, retired_o unchanged. Preload retired_o to all-ones, retire one instruction -> retired_o=0.
